hyper_mvblck_frdram: RTL and testbench
======================================

HYPER_MVBLCK_FRDRAM -- requirements
Module: hyper_mvblck_frdram

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; CLK is the clock and RST is the reset.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 START_ADDRESS  in  9  first DRAM column word address.
REQ-005 COUNT_REQ  in  6  words to move; 0 SHALL be legal.
REQ-006 SECTION  in  2  target LSAB section.
REQ-007 DRAM_SEL  in  2  MCU port code driven on requests; nonzero.
REQ-008 ISSUE  in  1  start pulse; sampled only in IDLE.
REQ-009 LSAB_0_FULL..LSAB_3_FULL  in  1 each  section cannot accept a write.
REQ-010 LSAB_WRITE  out  1  write strobe to the selected section.
REQ-011 LSAB_SECTION  out  2  latched SECTION.
REQ-012 LSAB_DATA  out  32  write data.
REQ-013 MCU_COLL_ADDRESS  out  9  request address; bit 0 always 0.
REQ-014 MCU_REQUEST_ACCESS  out  2  one-cycle DRAM_SEL pulse per pair request; 0 otherwise.
REQ-015 MCU_DATA_VALID  in  1  read word valid.
REQ-016 MCU_DATA  in  32  read word.
REQ-017 COUNT_SENT  out  6  words delivered in the last transfer.
REQ-018 WORKING  out  1  busy, delayed two cycles.
REQ-019 DONE  out  1  one-cycle completion pulse.

Function
REQ-020 States: IDLE, FETCH, DRAIN, FIN; FIN SHALL last exactly one cycle and return to IDLE.
REQ-021 IDLE + ISSUE: latch START_ADDRESS, COUNT_REQ, SECTION, DRAM_SEL; go FETCH, or FIN directly when COUNT_REQ=0.
REQ-022 Each request SHALL fetch one aligned word pair at {addr[8:1],0}; the MCU returns both words on two consecutive MCU_DATA_VALID cycles, in address order, at latency >= 2 cycles.
REQ-023 Requests SHALL be at least 2 cycles apart; the pair address increments by 2 and wraps from 510 to 0 modulo 512.
REQ-024 Pairs requested = ceil((START_ADDRESS[0] + COUNT_REQ) / 2); FETCH goes to DRAIN after the last request.
REQ-025 Internal FIFO: 4 x 32 bits. A request SHALL issue only when 4 - occupancy - outstanding_words >= 2, so returned data never overflows.
REQ-026 Odd START_ADDRESS: the first returned word SHALL be discarded.
REQ-027 Words beyond COUNT_REQ in the final pair SHALL be discarded; exactly COUNT_REQ words enter the FIFO.
REQ-028 LSAB_WRITE SHALL be 1 in a cycle iff the FIFO is non-empty and the selected LSAB_n_FULL is 0. LSAB_DATA is the FIFO head and is popped that cycle; no combinational path from MCU_DATA to LSAB_DATA.
REQ-029 FIFO push and pop in the same cycle SHALL keep occupancy unchanged.
REQ-030 FULL stalls SHALL only pause writes and, through credit, requests; no data is lost and there is no timeout.
REQ-031 DRAIN goes to FIN when all COUNT_REQ words are written. In FIN, DONE=1 and COUNT_SENT=COUNT_REQ (0 for the zero case); COUNT_SENT holds until the next FIN.
REQ-032 WORKING SHALL equal (state != IDLE) delayed by two registers.
REQ-033 ISSUE outside IDLE SHALL be ignored; MCU_DATA_VALID in IDLE SHALL be ignored.
REQ-034 Counters are 6 bits; the maximum transfer is 63 words with no overflow.

Reset
REQ-035 When RST=1 at a clock edge, the state SHALL go to IDLE, the FIFO and outstanding count SHALL clear, and LSAB_WRITE, MCU_REQUEST_ACCESS, DONE and WORKING (with both delay stages) SHALL go to 0.
REQ-036 When RST=1 at a clock edge, COUNT_SENT, MCU_COLL_ADDRESS and LSAB_SECTION SHALL go to 0.
REQ-037 Reset mid-transfer SHALL abandon the transfer immediately; late MCU data after reset SHALL be ignored.

Verification
REQ-038 START=0x010, COUNT=4, SECTION=2, FULLs=0 -> requests at 0x010 and 0x012; four LSAB_WRITE on section 2 in address order; DONE with COUNT_SENT=4.
REQ-039 START=0x011, COUNT=3 -> requests at 0x010 and 0x012; word 0x010 dropped; words 0x011, 0x012 and 0x013 written; COUNT_SENT=3.
REQ-040 START=0x1FE, COUNT=4 -> requests at 0x1FE then 0x000 (wrap); 4 words written.
REQ-041 COUNT=8, LSAB_2_FULL held 1 for 20 cycles -> at most 2 pairs outstanding plus buffered; no writes during the stall; after release all 8 words written in order.
REQ-042 COUNT=0 -> no MCU request; DONE one cycle after ISSUE; COUNT_SENT=0; WORKING pulses two cycles later.
REQ-043 RST=1 after the second request while data is in flight -> next cycle is IDLE with all outputs 0; late MCU_DATA_VALID is ignored; a following ISSUE runs cleanly.

Source files
------------

// File: rtl/hyper_mvblck_frdram.sv
// DRAM-to-LSAB block mover: fetches aligned word pairs from the MCU, trims to the
// requested window, buffers in a 4-deep FIFO and writes to the selected LSAB section.
module hyper_mvblck_frdram (
    input  logic        CLK,
    input  logic        RST,
    input  logic [8:0]  START_ADDRESS,
    input  logic [5:0]  COUNT_REQ,
    input  logic [1:0]  SECTION,
    input  logic [1:0]  DRAM_SEL,
    input  logic        ISSUE,
    input  logic        LSAB_0_FULL,
    input  logic        LSAB_1_FULL,
    input  logic        LSAB_2_FULL,
    input  logic        LSAB_3_FULL,
    output logic        LSAB_WRITE,
    output logic [1:0]  LSAB_SECTION,
    output logic [31:0] LSAB_DATA,
    output logic [8:0]  MCU_COLL_ADDRESS,
    output logic [1:0]  MCU_REQUEST_ACCESS,
    input  logic        MCU_DATA_VALID,
    input  logic [31:0] MCU_DATA,
    output logic [5:0]  COUNT_SENT,
    output logic        WORKING,
    output logic        DONE
);
    // state | meaning
    // IDLE  | waiting for ISSUE
    // FETCH | issuing pair requests as FIFO credit allows
    // DRAIN | all pairs requested, waiting for the last words to reach the LSAB
    // FIN   | one-cycle completion, DONE asserted
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    state_t      state;
    logic [7:0]  pair_addr;
    logic [5:0]  req_cnt;
    logic [5:0]  pairs_left;
    logic [5:0]  pushed_cnt;
    logic [5:0]  written_cnt;
    logic [1:0]  sel_q;
    logic        skip_first;
    logic [2:0]  occ;
    logic [2:0]  outstanding;
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic        working_d1;
    logic [31:0] fifo_mem [4];

    logic [3:0]  full_vec;
    logic        pop;
    logic        rx;
    logic        push;
    logic [3:0]  used;
    logic        issue_req;
    logic [5:0]  pairs_init;

    assign full_vec   = {LSAB_3_FULL, LSAB_2_FULL, LSAB_1_FULL, LSAB_0_FULL};
    assign pop        = (occ != 3'd0) && !full_vec[LSAB_SECTION];
    assign LSAB_WRITE = pop;
    assign LSAB_DATA  = (occ != 3'd0) ? fifo_mem[rd_ptr] : 32'd0;

    // stray valids (no outstanding words) are dropped so the counter cannot underflow
    assign rx   = MCU_DATA_VALID && (state == FETCH || state == DRAIN) && (outstanding != 3'd0);
    assign push = rx && !skip_first && (pushed_cnt != req_cnt);

    // a request needs room for both words of the pair in the 4-entry FIFO
    assign used      = {1'b0, occ} + {1'b0, outstanding};
    assign issue_req = (state == FETCH) && (pairs_left != 6'd0) &&
                       (MCU_REQUEST_ACCESS == 2'b00) && (used <= 4'd2);

    // ceil((start[0] + count) / 2) without a wide adder
    assign pairs_init = {1'b0, COUNT_REQ[5:1]} + {5'd0, COUNT_REQ[0] | START_ADDRESS[0]};

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= MCU_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= IDLE;
            pair_addr          <= 8'd0;
            req_cnt            <= 6'd0;
            pairs_left         <= 6'd0;
            pushed_cnt         <= 6'd0;
            written_cnt        <= 6'd0;
            sel_q              <= 2'd0;
            skip_first         <= 1'b0;
            occ                <= 3'd0;
            outstanding        <= 3'd0;
            wr_ptr             <= 2'd0;
            rd_ptr             <= 2'd0;
            working_d1         <= 1'b0;
            WORKING            <= 1'b0;
            DONE               <= 1'b0;
            COUNT_SENT         <= 6'd0;
            LSAB_SECTION       <= 2'd0;
            MCU_COLL_ADDRESS   <= 9'd0;
            MCU_REQUEST_ACCESS <= 2'd0;
        end else begin
            MCU_REQUEST_ACCESS <= 2'd0;
            DONE               <= 1'b0;
            working_d1         <= (state != IDLE);
            WORKING            <= working_d1;

            occ         <= occ + {2'b00, push} - {2'b00, pop};
            outstanding <= outstanding + (issue_req ? 3'd2 : 3'd0) - {2'b00, rx};
            if (rx) skip_first <= 1'b0;
            if (push) begin
                wr_ptr     <= wr_ptr + 2'd1;
                pushed_cnt <= pushed_cnt + 6'd1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 2'd1;
                written_cnt <= written_cnt + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (ISSUE) begin
                        pair_addr    <= START_ADDRESS[8:1];
                        skip_first   <= START_ADDRESS[0];
                        req_cnt      <= COUNT_REQ;
                        LSAB_SECTION <= SECTION;
                        sel_q        <= DRAM_SEL;
                        pairs_left   <= pairs_init;
                        pushed_cnt   <= 6'd0;
                        written_cnt  <= 6'd0;
                        if (COUNT_REQ == 6'd0) begin
                            state      <= FIN;
                            DONE       <= 1'b1;
                            COUNT_SENT <= 6'd0;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue_req) begin
                        MCU_REQUEST_ACCESS <= sel_q;
                        MCU_COLL_ADDRESS   <= {pair_addr, 1'b0};
                        pair_addr          <= pair_addr + 8'd1;
                        pairs_left         <= pairs_left - 6'd1;
                        if (pairs_left == 6'd1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (written_cnt == req_cnt && outstanding == 3'd0) begin
                        state      <= FIN;
                        DONE       <= 1'b1;
                        COUNT_SENT <= req_cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hyper_mvblck_frdram.sv
// Bench for hyper_mvblck_frdram: MCU responder with random latency, LSAB stall
// stimulus, and an address-window reference model for requests and written words.
module tb_hyper_mvblck_frdram;
    logic        CLK = 1'b0;
    logic        RST;
    logic [8:0]  START_ADDRESS;
    logic [5:0]  COUNT_REQ;
    logic [1:0]  SECTION;
    logic [1:0]  DRAM_SEL;
    logic        ISSUE;
    logic        LSAB_0_FULL, LSAB_1_FULL, LSAB_2_FULL, LSAB_3_FULL;
    logic        LSAB_WRITE;
    logic [1:0]  LSAB_SECTION;
    logic [31:0] LSAB_DATA;
    logic [8:0]  MCU_COLL_ADDRESS;
    logic [1:0]  MCU_REQUEST_ACCESS;
    logic        MCU_DATA_VALID;
    logic [31:0] MCU_DATA;
    logic [5:0]  COUNT_SENT;
    logic        WORKING;
    logic        DONE;

    always #5 CLK = ~CLK;

    hyper_mvblck_frdram dut (
        .CLK(CLK), .RST(RST), .START_ADDRESS(START_ADDRESS), .COUNT_REQ(COUNT_REQ),
        .SECTION(SECTION), .DRAM_SEL(DRAM_SEL), .ISSUE(ISSUE),
        .LSAB_0_FULL(LSAB_0_FULL), .LSAB_1_FULL(LSAB_1_FULL),
        .LSAB_2_FULL(LSAB_2_FULL), .LSAB_3_FULL(LSAB_3_FULL),
        .LSAB_WRITE(LSAB_WRITE), .LSAB_SECTION(LSAB_SECTION), .LSAB_DATA(LSAB_DATA),
        .MCU_COLL_ADDRESS(MCU_COLL_ADDRESS), .MCU_REQUEST_ACCESS(MCU_REQUEST_ACCESS),
        .MCU_DATA_VALID(MCU_DATA_VALID), .MCU_DATA(MCU_DATA),
        .COUNT_SENT(COUNT_SENT), .WORKING(WORKING), .DONE(DONE)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // monitor / MCU responder state
    int          ncyc = 0;
    logic [3:0]  full_vec = 4'd0;
    bit          rand_full = 1'b0;
    int          rsp_cyc[$];
    logic [8:0]  rsp_addr[$];
    int          last_rsp = 0;
    logic [8:0]  req_addr_log[$];
    logic [1:0]  req_sel_log[$];
    logic [31:0] wr_data_log[$];
    logic [1:0]  wr_sec_log[$];
    int          done_cnt = 0, done_cyc = 0;
    logic [5:0]  sent_at_done = 6'd0;
    int          work_first = 0, work_last = 0, work_cnt = 0;
    bit          track = 1'b0;
    int          ret_idx = 0, skip_n = 0, cnt_n = 0;
    int          outst = 0, buffered = 0, max_credit = 0, stall_viol = 0;
    logic [22:0] salt = 23'd0;

    function automatic logic [31:0] mk_word(input logic [8:0] a);
        return {salt, a};
    endfunction

    always @(negedge CLK) begin
        int lat, t;
        ncyc++;
        if (rand_full)
            for (int i = 0; i < 4; i++) full_vec[i] = ($urandom_range(0, 2) == 0);
        {LSAB_3_FULL, LSAB_2_FULL, LSAB_1_FULL, LSAB_0_FULL} = full_vec;
        MCU_DATA_VALID = 1'b0;
        MCU_DATA = $urandom;
        if (rsp_cyc.size() != 0 && rsp_cyc[0] == ncyc) begin
            MCU_DATA_VALID = 1'b1;
            MCU_DATA = mk_word(rsp_addr[0]);
            void'(rsp_cyc.pop_front());
            void'(rsp_addr.pop_front());
            if (track) begin
                outst--;
                if (ret_idx >= skip_n && ret_idx < skip_n + cnt_n) buffered++;
                ret_idx++;
            end
        end
        #1;
        if (MCU_REQUEST_ACCESS != 2'd0) begin
            req_addr_log.push_back(MCU_COLL_ADDRESS);
            req_sel_log.push_back(MCU_REQUEST_ACCESS);
            lat = int'($urandom_range(2, 5));
            t = ncyc + lat;
            if (t <= last_rsp) t = last_rsp + 1;
            rsp_cyc.push_back(t);
            rsp_addr.push_back(MCU_COLL_ADDRESS);
            rsp_cyc.push_back(t + 1);
            rsp_addr.push_back(MCU_COLL_ADDRESS + 9'd1);
            last_rsp = t + 1;
            if (track) outst += 2;
        end
        if (LSAB_WRITE) begin
            wr_data_log.push_back(LSAB_DATA);
            wr_sec_log.push_back(LSAB_SECTION);
            if (track) buffered--;
            if (full_vec[LSAB_SECTION]) stall_viol++;
        end
        if (outst + buffered > max_credit) max_credit = outst + buffered;
        if (DONE) begin
            done_cnt++;
            done_cyc = ncyc;
            sent_at_done = COUNT_SENT;
        end
        if (WORKING) begin
            if (work_cnt == 0) work_first = ncyc;
            work_last = ncyc;
            work_cnt++;
        end
    end

    task automatic step();
        @(negedge CLK);
        #2;
    endtask

    task automatic clear_logs();
        req_addr_log.delete();
        req_sel_log.delete();
        wr_data_log.delete();
        wr_sec_log.delete();
        done_cnt = 0;
        work_cnt = 0;
    endtask

    task automatic wait_mcu_quiet();
        int b = 0;
        while (rsp_cyc.size() != 0 && b < 100) begin
            step();
            b++;
        end
    endtask

    task automatic run_xfer(input logic [8:0] sa, input logic [5:0] cnt, input logic [1:0] sec,
                            input logic [1:0] sel, input bit rf, input int stall, input bit poke);
        logic [8:0]  exp_req[$];
        logic [31:0] exp_wd[$];
        int npairs, n0, budget, nr, nw;
        wait_mcu_quiet();
        step();
        clear_logs();
        ret_idx = 0; skip_n = int'(sa[0]); cnt_n = int'(cnt);
        outst = 0; buffered = 0; max_credit = 0; stall_viol = 0;
        track = 1'b1;
        salt = 23'($urandom);
        npairs = (int'(sa[0]) + int'(cnt) + 1) / 2;
        for (int i = 0; i < npairs; i++) exp_req.push_back(9'(int'(sa & 9'h1FE) + 2 * i));
        for (int i = 0; i < int'(cnt); i++) exp_wd.push_back(mk_word(9'(int'(sa) + i)));
        rand_full = rf;
        full_vec = 4'd0;
        if (stall > 0) full_vec[sec] = 1'b1;
        START_ADDRESS = sa; COUNT_REQ = cnt; SECTION = sec; DRAM_SEL = sel;
        ISSUE = 1'b1;
        n0 = ncyc;
        step();
        ISSUE = 1'b0;
        budget = 0;
        while (done_cnt == 0 && budget < 3000) begin
            if (stall > 0 && budget == stall) full_vec[sec] = 1'b0;
            START_ADDRESS = 9'($urandom); COUNT_REQ = 6'($urandom);
            SECTION = 2'($urandom); DRAM_SEL = 2'($urandom_range(1, 3));
            ISSUE = (poke && budget == 3);
            step();
            budget++;
        end
        ISSUE = 1'b0;
        rand_full = 1'b0;
        full_vec = 4'd0;
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        for (int i = 0; i < 6; i++) step();
        check("done_width", 32'(done_cnt), 32'd1);
        check("count_sent_at_done", 32'(sent_at_done), 32'(cnt));
        check("count_sent_hold", 32'(COUNT_SENT), 32'(cnt));
        nr = req_addr_log.size();
        nw = wr_data_log.size();
        check("req_count", 32'(nr), 32'(npairs));
        for (int i = 0; i < nr && i < npairs; i++) begin
            check("req_addr", 32'(req_addr_log[i]), 32'(exp_req[i]));
            check("req_sel", 32'(req_sel_log[i]), 32'(sel));
        end
        check("write_count", 32'(nw), 32'(cnt));
        for (int i = 0; i < nw && i < int'(cnt); i++) begin
            check("write_data", wr_data_log[i], exp_wd[i]);
            check("write_section", 32'(wr_sec_log[i]), 32'(sec));
        end
        check("credit_bound", 32'(max_credit <= 4), 32'd1);
        check("no_write_when_full", 32'(stall_viol), 32'd0);
        check("working_start", 32'(work_first), 32'(n0 + 3));
        check("working_end", 32'(work_last), 32'(done_cyc + 2));
        check("working_contiguous", 32'(work_cnt), 32'(work_last - work_first + 1));
        if (cnt == 6'd0) check("done_latency", 32'(done_cyc), 32'(n0 + 1));
        track = 1'b0;
    endtask

    task automatic reset_mid();
        int budget, nw, nr;
        wait_mcu_quiet();
        step();
        clear_logs();
        track = 1'b0;
        salt = 23'($urandom);
        START_ADDRESS = 9'h040; COUNT_REQ = 6'd20; SECTION = 2'd1; DRAM_SEL = 2'd1;
        ISSUE = 1'b1;
        step();
        ISSUE = 1'b0;
        budget = 0;
        while (req_addr_log.size() < 2 && budget < 200) begin
            step();
            budget++;
        end
        check("rst_second_req_seen", 32'(req_addr_log.size() >= 2), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rst_lsab_write", 32'(LSAB_WRITE), 32'd0);
        check("rst_lsab_data", LSAB_DATA, 32'd0);
        check("rst_req_access", 32'(MCU_REQUEST_ACCESS), 32'd0);
        check("rst_coll_addr", 32'(MCU_COLL_ADDRESS), 32'd0);
        check("rst_section", 32'(LSAB_SECTION), 32'd0);
        check("rst_count_sent", 32'(COUNT_SENT), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_working", 32'(WORKING), 32'd0);
        nw = wr_data_log.size();
        nr = req_addr_log.size();
        done_cnt = 0;
        work_cnt = 0;
        for (int i = 0; i < 15; i++) step();
        check("rst_late_data_ignored", 32'(wr_data_log.size() - nw), 32'd0);
        check("rst_no_new_req", 32'(req_addr_log.size() - nr), 32'd0);
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_working_idle", 32'(work_cnt), 32'd0);
    endtask

    initial begin
        RST = 1'b1; ISSUE = 1'b0;
        START_ADDRESS = 9'd0; COUNT_REQ = 6'd0; SECTION = 2'd0; DRAM_SEL = 2'd1;
        for (int i = 0; i < 3; i++) step();
        RST = 1'b0;
        check("reset_lsab_write", 32'(LSAB_WRITE), 32'd0);
        check("reset_req_access", 32'(MCU_REQUEST_ACCESS), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_working", 32'(WORKING), 32'd0);
        check("reset_count_sent", 32'(COUNT_SENT), 32'd0);
        check("reset_coll_addr", 32'(MCU_COLL_ADDRESS), 32'd0);
        check("reset_section", 32'(LSAB_SECTION), 32'd0);
        step();

        run_xfer(9'h010, 6'd4, 2'd2, 2'd1, 1'b0, 0, 1'b0);
        run_xfer(9'h011, 6'd3, 2'd0, 2'd2, 1'b0, 0, 1'b0);
        run_xfer(9'h1FE, 6'd4, 2'd1, 2'd3, 1'b0, 0, 1'b0);
        run_xfer(9'h020, 6'd0, 2'd3, 2'd1, 1'b0, 0, 1'b0);
        run_xfer(9'h100, 6'd8, 2'd2, 2'd1, 1'b0, 20, 1'b0);
        reset_mid();
        run_xfer(9'h010, 6'd4, 2'd2, 2'd1, 1'b0, 0, 1'b0);
        run_xfer(9'h1C1, 6'd63, 2'd3, 2'd2, 1'b1, 0, 1'b1);

        for (int k = 0; k < 14; k++) begin
            run_xfer(9'($urandom_range(0, 511)), 6'($urandom_range(0, 63)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)),
                     1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
